truth_table_sweeper: RTL and testbench
======================================

// Module: truth_table_sweeper
// PURPOSE
//  Sequencer that exhaustively exercises a 3-input, 1-output combinational gate
//  (default: function 0x79) and checks its response.
//  - Drives all 8 input vectors in order, waits a programmable settle window per
//    vector, then samples the gate output.
//  - Compares the captured truth table against RULE and reports pass/fail plus a
//    per-vector mismatch mask.
//  - Sits beside the gate as its on-chip self-test / characterisation controller.
// PARAMETERS
//  RULE           8'h79  expected truth table; bit i = expected out for {in1,in2,in3}=i
//  SETTLE_CYCLES  4      clocks each vector is held before sampling; legal range 1..255
//  SYNC_STAGES    2      flops on dut_out before sampling; legal range 0..3
// PORTS
//  clk       in   1  single clock, rising edge
//  reset     in   1  asynchronous, active-high; clears all state
//  start     in   1  begin a sweep; honoured only in IDLE
//  abort     in   1  cancel an in-progress sweep
//  dut_in1   out  1  gate input 1 (MSB of vector index)
//  dut_in2   out  1  gate input 2
//  dut_in3   out  1  gate input 3 (LSB of vector index)
//  dut_out   in   1  gate output; may be asynchronous to clk
//  busy      out  1  high while sweeping
//  done      out  1  single-cycle pulse when a sweep completes
//  pass      out  1  high when the last completed sweep matched RULE
//  result    out  8  captured truth table; bit i = sampled out for vector i
//  mismatch  out  8  result ^ RULE, valid after done
// BEHAVIOUR
//  Reset
//  - state=IDLE, idx=0, cnt=0, sync flops=0.
//  - All outputs 0: dut_in*=000, busy, done, pass, result and mismatch all 0.
//  States: IDLE, SWEEP, DONE
//  - IDLE->SWEEP: on the edge sampling start=1 && abort=0.
//    - idx=0, cnt=0, result=0, mismatch=0, pass=0, busy=1.
//  - SWEEP: {dut_in1,dut_in2,dut_in3}=idx[2:0], registered. cnt increments every edge.
//    - At the edge where cnt==SETTLE_CYCLES-1: result[idx] <= synced dut_out, cnt <= 0.
//      - If idx<7: idx <= idx+1; next vector is driven from this same edge.
//      - If idx==7: go to DONE, busy <= 0.
//    - Each vector is held exactly SETTLE_CYCLES clocks.
//    - Effective gate settle time = SETTLE_CYCLES - SYNC_STAGES clocks.
//  - DONE: lasts one cycle; then IDLE.
//    - done=1; mismatch=result^RULE; pass=(result==RULE).
//  - Timing: done goes high 8*SETTLE_CYCLES clocks after the start edge.
//  - After a sweep, dut_in* return to 000 in IDLE.
//  - result, mismatch and pass hold until the next accepted start or reset.
//  Abort
//  - abort=1 in SWEEP: next state IDLE, busy=0, dut_in*=000, pass=0, no done pulse.
//    - result keeps the bits already captured; mismatch stays 0.
//  - abort in IDLE or DONE: no effect.
//  - start && abort in the same IDLE cycle: abort wins; remain IDLE.
//  Boundary conditions
//  - start while busy or in DONE: ignored; no restart, no queuing.
//  - reset asserted mid-sweep: immediate return to reset values regardless of clk.
//  - SETTLE_CYCLES==1: a new vector every clock; total sweep = 8 clocks.
//  - cnt is 8 bits and never wraps past SETTLE_CYCLES-1.
//  - idx is 3 bits; it never wraps because SWEEP exits at idx==7.
// TESTING
//  1. Ideal 0x79 gate model, S=4, SYNC=2: pulse start -> dut_in steps 000..111
//     every 4 clks; done at +32; result=8'h79, mismatch=0, pass=1.
//  2. Gate stuck-at-0 -> result=8'h00, mismatch=8'h79, pass=0, done still pulses.
//  3. Abort during vector 3 (idx==3) -> busy=0 next clk; dut_in=000; no done;
//     pass=0; result[2:0]=3'b001.
//  4. Second start pulse at clk 10 of a sweep -> ignored; done still at +32;
//     exactly one done pulse.
//  5. Async reset mid-sweep at idx 5 -> all outputs 0 immediately;
//     a new start then completes with pass=1.
//  6. S=1, gate delay of 2 clks, SYNC=0 -> result shifted/corrupted, pass=0;
//     proves the settle window is enforced.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// Self-test sequencer for a 3-input, 1-output combinational gate.
// Walks all 8 input vectors, holds each for SETTLE_CYCLES clocks, samples the
// (optionally synchronised) gate output, then compares the captured truth table
// against RULE and reports pass/fail plus a per-vector mismatch mask.
module truth_table_sweeper #(
  parameter logic [7:0]  RULE          = 8'h79,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  output logic       dut_in1,
  output logic       dut_in2,
  output logic       dut_in3,
  input  logic       dut_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] result,
  output logic [7:0] mismatch
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SWEEP,
    ST_DONE
  } state_t;

  localparam logic [7:0] LP_CNT_LAST = 8'(SETTLE_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_next;

  logic [2:0]  r_idx;
  logic [2:0]  w_idx_next;
  logic [7:0]  r_cnt;
  logic [7:0]  w_cnt_next;
  logic [2:0]  r_vec;
  logic [2:0]  w_vec_next;
  logic [7:0]  r_result;
  logic [7:0]  w_result_next;
  logic [7:0]  r_mismatch;
  logic [7:0]  w_mismatch_next;
  logic        r_pass;
  logic        w_pass_next;
  logic        r_done;
  logic        w_done_next;
  logic        r_busy;
  logic        w_busy_next;

  logic        w_synced;

  // Synchroniser chain on the gate output; zero stages samples it directly.
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign w_synced = dut_out;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] r_sync;

      // Shift the raw gate output through the synchroniser flops.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_sync <= '0;
        end else begin
          r_sync[0] <= dut_out;
          for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
            r_sync[k] <= r_sync[k-1];
          end
        end
      end

      assign w_synced = r_sync[SYNC_STAGES-1];
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and datapath next-value logic.
  always_comb begin
    w_state_next    = r_state;
    w_idx_next      = r_idx;
    w_cnt_next      = r_cnt;
    w_vec_next      = r_vec;
    w_result_next   = r_result;
    w_mismatch_next = r_mismatch;
    w_pass_next     = r_pass;
    w_done_next     = 1'b0;
    w_busy_next     = r_busy;

    case (r_state)
      ST_IDLE: begin
        w_vec_next  = '0;
        w_busy_next = 1'b0;
        // abort has priority over a coincident start
        if (start && !abort) begin
          w_state_next    = ST_SWEEP;
          w_idx_next      = '0;
          w_cnt_next      = '0;
          w_result_next   = '0;
          w_mismatch_next = '0;
          w_pass_next     = 1'b0;
          w_busy_next     = 1'b1;
        end
      end

      ST_SWEEP: begin
        if (abort) begin
          w_state_next = ST_IDLE;
          w_idx_next   = '0;
          w_cnt_next   = '0;
          w_vec_next   = '0;
          w_busy_next  = 1'b0;
          w_pass_next  = 1'b0;
        end else if (r_cnt == LP_CNT_LAST) begin
          w_cnt_next             = '0;
          w_result_next[r_idx]   = w_synced;
          if (r_idx == 3'd7) begin
            // Verdict is formed from the table including the bit captured
            // on this edge, so it is already valid while done is high.
            w_state_next    = ST_DONE;
            w_busy_next     = 1'b0;
            w_vec_next      = '0;
            w_done_next     = 1'b1;
            w_mismatch_next = w_result_next ^ RULE;
            w_pass_next     = (w_result_next == RULE);
          end else begin
            w_idx_next = r_idx + 3'd1;
            w_vec_next = r_idx + 3'd1;
          end
        end else begin
          w_cnt_next = r_cnt + 8'd1;
        end
      end

      ST_DONE: begin
        w_state_next = ST_IDLE;
        w_vec_next   = '0;
        w_busy_next  = 1'b0;
      end

      default: begin
        w_state_next = ST_IDLE;
        w_vec_next   = '0;
        w_busy_next  = 1'b0;
      end
    endcase
  end

  // Datapath registers: vector index, settle counter, drive vector, results.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx      <= '0;
      r_cnt      <= '0;
      r_vec      <= '0;
      r_result   <= '0;
      r_mismatch <= '0;
      r_pass     <= 1'b0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_idx      <= w_idx_next;
      r_cnt      <= w_cnt_next;
      r_vec      <= w_vec_next;
      r_result   <= w_result_next;
      r_mismatch <= w_mismatch_next;
      r_pass     <= w_pass_next;
      r_done     <= w_done_next;
      r_busy     <= w_busy_next;
    end
  end

  assign dut_in1  = r_vec[2];
  assign dut_in2  = r_vec[1];
  assign dut_in3  = r_vec[0];
  assign busy     = r_busy;
  assign done     = r_done;
  assign pass     = r_pass;
  assign result   = r_result;
  assign mismatch = r_mismatch;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: one instance with an ideal/stuck gate
// (S=4, SYNC=2) and one with a 2-clock-delayed gate (S=1, SYNC=0).
module tb_truth_table_sweeper;

  typedef struct packed {
    int         cyc;
    logic [7:0] res;
    logic [7:0] mm;
    logic       ps;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       start1, abort1, start2, abort2;
  logic       in1_a, in2_a, in3_a, out_a;
  logic       in1_b, in2_b, in3_b, out_b;
  logic       busy1, done1, pass1, busy2, done2, pass2;
  logic [7:0] result1, mismatch1, result2, mismatch2;
  logic [2:0] vec1, vec2;
  logic [7:0] rule_tb = 8'h79;
  logic       gate_mode = 1'b0;
  logic       gd1 = 1'b1;
  logic       gd2 = 1'b1;

  int cyc   = 0;
  int total = 0;
  int bad   = 0;
  int s;

  exp_t q1[$];
  exp_t q2[$];

  truth_table_sweeper #(
    .RULE(8'h79), .SETTLE_CYCLES(4), .SYNC_STAGES(2)
  ) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .abort(abort1),
    .dut_in1(in1_a), .dut_in2(in2_a), .dut_in3(in3_a), .dut_out(out_a),
    .busy(busy1), .done(done1), .pass(pass1), .result(result1), .mismatch(mismatch1)
  );

  truth_table_sweeper #(
    .RULE(8'h79), .SETTLE_CYCLES(1), .SYNC_STAGES(0)
  ) u_dut2 (
    .clk(clk), .reset(reset), .start(start2), .abort(abort2),
    .dut_in1(in1_b), .dut_in2(in2_b), .dut_in3(in3_b), .dut_out(out_b),
    .busy(busy2), .done(done2), .pass(pass2), .result(result2), .mismatch(mismatch2)
  );

  assign vec1  = {in1_a, in2_a, in3_a};
  assign vec2  = {in1_b, in2_b, in3_b};
  assign out_a = gate_mode ? 1'b0 : rule_tb[vec1];
  assign out_b = gd2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    gd1 <= rule_tb[vec2];
    gd2 <= gd1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (done1) begin
      if (q1.size() == 0) begin
        chk("dut1 unexpected done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("dut1 done cycle", cyc, e.cyc);
        chk("dut1 result", {24'd0, result1}, {24'd0, e.res});
        chk("dut1 mismatch", {24'd0, mismatch1}, {24'd0, e.mm});
        chk("dut1 pass", {31'd0, pass1}, {31'd0, e.ps});
        chk("dut1 busy at done", {31'd0, busy1}, 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (done2) begin
      if (q2.size() == 0) begin
        chk("dut2 unexpected done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q2.pop_front();
        chk("dut2 done cycle", cyc, e.cyc);
        chk("dut2 result", {24'd0, result2}, {24'd0, e.res});
        chk("dut2 mismatch", {24'd0, mismatch2}, {24'd0, e.mm});
        chk("dut2 pass", {31'd0, pass2}, {31'd0, e.ps});
      end
    end
  end

  task automatic start_sweep1(output int st);
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    st = cyc;
  endtask

  task automatic check_all_zero1(input string tag);
    chk({tag, " vec"}, {29'd0, vec1}, 32'd0);
    chk({tag, " busy"}, {31'd0, busy1}, 32'd0);
    chk({tag, " done"}, {31'd0, done1}, 32'd0);
    chk({tag, " pass"}, {31'd0, pass1}, 32'd0);
    chk({tag, " result"}, {24'd0, result1}, 32'd0);
    chk({tag, " mismatch"}, {24'd0, mismatch1}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset  = 1'b1;
    start1 = 1'b0; abort1 = 1'b0;
    start2 = 1'b0; abort2 = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero1("reset");
    chk("reset dut2 busy", {31'd0, busy2}, 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // 1: ideal gate, full sweep
    start_sweep1(s);
    q1.push_back('{cyc: s + 32, res: 8'h79, mm: 8'h00, ps: 1'b1});
    chk("t1 busy after start", {31'd0, busy1}, 32'd1);
    for (int k = 0; k < 8; k++) begin
      chk("t1 vector", {29'd0, vec1}, k);
      repeat (4) @(negedge clk);
    end
    repeat (8) @(negedge clk);
    chk("t1 pass held", {31'd0, pass1}, 32'd1);
    chk("t1 result held", {24'd0, result1}, 32'h79);
    chk("t1 vec idle", {29'd0, vec1}, 32'd0);

    // start and abort together in IDLE: abort wins
    @(negedge clk) begin start1 = 1'b1; abort1 = 1'b1; end
    @(negedge clk) begin start1 = 1'b0; abort1 = 1'b0; end
    chk("start+abort busy", {31'd0, busy1}, 32'd0);
    @(negedge clk);
    chk("start+abort busy later", {31'd0, busy1}, 32'd0);
    chk("start+abort pass kept", {31'd0, pass1}, 32'd1);

    // 2: stuck-at-0 gate
    gate_mode = 1'b1;
    repeat (4) @(negedge clk);
    start_sweep1(s);
    q1.push_back('{cyc: s + 32, res: 8'h00, mm: 8'h79, ps: 1'b0});
    repeat (40) @(negedge clk);
    gate_mode = 1'b0;
    repeat (4) @(negedge clk);

    // 3: abort during vector 3
    start_sweep1(s);
    repeat (12) @(negedge clk);
    chk("t3 vector 3", {29'd0, vec1}, 32'd3);
    abort1 = 1'b1;
    @(negedge clk) abort1 = 1'b0;
    chk("t3 busy", {31'd0, busy1}, 32'd0);
    chk("t3 vec", {29'd0, vec1}, 32'd0);
    chk("t3 pass", {31'd0, pass1}, 32'd0);
    chk("t3 result", {24'd0, result1}, 32'h01);
    chk("t3 mismatch", {24'd0, mismatch1}, 32'h00);
    repeat (40) @(negedge clk);

    // 4: second start at clk 10 ignored
    start_sweep1(s);
    q1.push_back('{cyc: s + 32, res: 8'h79, mm: 8'h00, ps: 1'b1});
    repeat (10) @(negedge clk);
    start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    chk("t4 still busy", {31'd0, busy1}, 32'd1);
    repeat (40) @(negedge clk);

    // 5: async reset at vector 5, then clean sweep
    start_sweep1(s);
    repeat (21) @(negedge clk);
    chk("t5 vector 5", {29'd0, vec1}, 32'd5);
    chk("t5 partial result", {24'd0, result1}, 32'h19);
    #2 reset = 1'b1;
    #1 check_all_zero1("t5 async reset");
    @(negedge clk) reset = 1'b0;
    repeat (4) @(negedge clk);
    start_sweep1(s);
    q1.push_back('{cyc: s + 32, res: 8'h79, mm: 8'h00, ps: 1'b1});
    repeat (40) @(negedge clk);

    // 6: S=1, no sync, 2-clock gate delay
    @(negedge clk) start2 = 1'b1;
    @(negedge clk) start2 = 1'b0;
    s = cyc;
    q2.push_back('{cyc: s + 8, res: 8'hE7, mm: 8'h9E, ps: 1'b0});
    chk("t6 busy", {31'd0, busy2}, 32'd1);
    repeat (16) @(negedge clk);

    chk("dut1 expected dones all seen", q1.size(), 32'd0);
    chk("dut2 expected dones all seen", q2.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
